// File: rtl/uart_transmitter_pkg.sv
// ---------------------------------------------------------------------------
// uart_transmitter_pkg
// Shared UART frame-format codes, clock constants, TX FSM state encoding and
// small frame-format helpers used by the transmitter.
// ---------------------------------------------------------------------------
package uart_transmitter_pkg;

    // Data width codes (number of data bits = code + 5)
    localparam logic [1:0] DW_5BIT = 2'd0;
    localparam logic [1:0] DW_6BIT = 2'd1;
    localparam logic [1:0] DW_7BIT = 2'd2;
    localparam logic [1:0] DW_8BIT = 2'd3;

    // Stop bit codes; anything other than SB_2BIT means one stop bit
    localparam logic [1:0] SB_1BIT = 2'd0;
    localparam logic [1:0] SB_2BIT = 2'd1;

    // Parity mode codes
    localparam logic [1:0] EVEN      = 2'd0;
    localparam logic [1:0] ODD       = 2'd1;
    localparam logic [1:0] DISABLED1 = 2'd2;
    localparam logic [1:0] DISABLED2 = 2'd3;

    localparam int unsigned SYSTEM_CLOCK_FREQ = 50_000_000;
    localparam int unsigned COUNT_10MS        = SYSTEM_CLOCK_FREQ / 100;

    // TX FSM state encoding
    typedef logic [2:0] tx_state_t;
    localparam tx_state_t TX_IDLE       = 3'd0;
    localparam tx_state_t TX_START      = 3'd1;
    localparam tx_state_t TX_DATA       = 3'd2;
    localparam tx_state_t TX_PARITY     = 3'd3;
    localparam tx_state_t TX_STOP       = 3'd4;
    localparam tx_state_t TX_CONFIG_REQ = 3'd5;

    // Byte and format latched at frame start
    typedef struct packed {
        logic [7:0] data;
        logic [1:0] dw;
        logic [1:0] sb;
        logic [1:0] pm;
    } tx_frame_t;

    // Index of the last data bit sent for a width code
    function automatic logic [2:0] data_last_idx(input logic [1:0] dw);
        case (dw)
            DW_5BIT: data_last_idx = 3'd4;
            DW_6BIT: data_last_idx = 3'd5;
            DW_7BIT: data_last_idx = 3'd6;
            default: data_last_idx = 3'd7;
        endcase
    endfunction

    function automatic logic parity_enabled(input logic [1:0] pm);
        case (pm)
            EVEN, ODD:            parity_enabled = 1'b1;
            DISABLED1, DISABLED2: parity_enabled = 1'b0;
            default:              parity_enabled = 1'b0;
        endcase
    endfunction

    // XOR over only the transmitted bits, inverted for odd parity
    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic [1:0] dw,
                                        input logic [1:0] pm);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - dw);
        parity_bit = (^(data & mask)) ^ (pm == ODD);
    endfunction

endpackage

// File: rtl/uart_transmitter_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always visible
// on rd_data_o while not empty; rd_en_i pops it.
// Ports:
//   clk_i, rst_i       clock, async active-high reset
//   wr_en_i/wr_data_i  enqueue; dropped while full unless a pop happens too
//   rd_en_i            pop head (ignored while empty)
//   rd_data_o          head entry
//   full_o, empty_o    registered flags, reflect state after this cycle
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             wr_acc, rd_acc;

    // A pop frees the slot in the same cycle, so a write while full is
    // accepted when it coincides with a pop.
    assign rd_acc  = rd_en_i && !empty_q;
    assign wr_acc  = wr_en_i && (!full_q || rd_acc);
    assign count_d = count_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
// Buffers host bytes in a TX FIFO and serializes each one on tx_o as
// start, 5..8 data bits (LSB first), optional parity, 1 or 2 stop bits.
// Bit timing is OVERSAMPLE strobes of ov_baud_rt_i per serial bit.
// Optional build macro UART_TX_CONFIG_REQ_EN adds send_config_req_i, which
// holds the line low for 10*COUNT_10MS clocks, then high for one bit time.
// Ports:
//   clk_i, rst_i               clock, async active-high reset
//   ov_baud_rt_i               oversample strobe
//   data_tx_i/tx_fifo_write_i  FIFO enqueue
//   data_width_i, stop_bits_number_i, parity_mode_i  frame format
//   tx_enable_i                allows a new frame to start
//   tx_o                       serial line (registered, idle high)
//   tx_fifo_full_o/empty_o     FIFO flags
//   tx_busy_o                  frame in progress
//   tx_done_o                  1-cycle pulse after the last stop bit
// ---------------------------------------------------------------------------
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ov_baud_rt_i,
    input  logic [7:0] data_tx_i,
    input  logic       tx_fifo_write_i,
    input  logic [1:0] data_width_i,
    input  logic [1:0] stop_bits_number_i,
    input  logic [1:0] parity_mode_i,
    input  logic       tx_enable_i,
`ifdef UART_TX_CONFIG_REQ_EN
    input  logic       send_config_req_i,
`endif
    output logic       tx_o,
    output logic       tx_fifo_full_o,
    output logic       tx_fifo_empty_o,
    output logic       tx_busy_o,
    output logic       tx_done_o
);

    localparam logic [3:0] OV_LAST = 4'(OVERSAMPLE - 1);

    tx_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    tx_frame_t  frame_q, frame_d;
    logic       tx_q, tx_d;
    logic       done_q, done_d;
    logic       bit_end, start_ok, launch;
    logic [7:0] fifo_head;
    logic       fifo_empty;

`ifdef UART_TX_CONFIG_REQ_EN
    localparam int unsigned CFG_CYCLES = COUNT_10MS * 10;
    localparam int unsigned CFG_W      = $clog2(CFG_CYCLES);
    logic [CFG_W-1:0] cfg_cnt_q, cfg_cnt_d;
    logic             cfg_hi_q, cfg_hi_d;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (tx_fifo_write_i),
        .wr_data_i (data_tx_i),
        .rd_en_i   (launch),
        .rd_data_o (fifo_head),
        .full_o    (tx_fifo_full_o),
        .empty_o   (fifo_empty)
    );

    assign bit_end  = ov_baud_rt_i && (cnt_q == OV_LAST);
    assign start_ok = tx_enable_i && !fifo_empty;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        done_d    = 1'b0;
        launch    = 1'b0;
`ifdef UART_TX_CONFIG_REQ_EN
        cfg_cnt_d = cfg_cnt_q;
        cfg_hi_d  = cfg_hi_q;
`endif
        if (ov_baud_rt_i) cnt_d = bit_end ? 4'd0 : cnt_q + 4'd1;

        case (state_q)
            TX_IDLE: begin
                cnt_d = 4'd0;
`ifdef UART_TX_CONFIG_REQ_EN
                if (send_config_req_i) begin
                    state_d   = TX_CONFIG_REQ;
                    cfg_cnt_d = '0;
                    cfg_hi_d  = 1'b0;
                end else
`endif
                if (start_ok) launch = 1'b1;
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == data_last_idx(frame_q.dw)) begin
                        state_d   = parity_enabled(frame_q.pm) ? TX_PARITY : TX_STOP;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    state_d   = TX_STOP;
                    bit_idx_d = 3'd0;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    // bit_idx counts stop bits; 1 is only reached with two
                    if ((frame_q.sb != SB_2BIT) || (bit_idx_q == 3'd1)) begin
                        done_d  = 1'b1;
                        state_d = TX_IDLE;
                        // Chain straight into the next frame with no idle bit
                        if (start_ok) launch = 1'b1;
                    end else begin
                        bit_idx_d = 3'd1;
                    end
                end
            end
`ifdef UART_TX_CONFIG_REQ_EN
            TX_CONFIG_REQ: begin
                if (!cfg_hi_q) begin
                    // Low phase is timed in clocks; hold the bit timer parked
                    cnt_d = 4'd0;
                    if (cfg_cnt_q == CFG_W'(CFG_CYCLES - 1)) cfg_hi_d = 1'b1;
                    else cfg_cnt_d = cfg_cnt_q + 1'b1;
                end else if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = TX_IDLE;
                end
            end
`endif
            default: state_d = TX_IDLE;
        endcase

        if (launch) begin
            frame_d = '{data: fifo_head, dw: data_width_i,
                        sb: stop_bits_number_i, pm: parity_mode_i};
            state_d = TX_START;
            cnt_d   = 4'd0;
        end

        // Line level follows the next state so tx_o changes with it
        tx_d = 1'b1;
        case (state_d)
            TX_START:      tx_d = 1'b0;
            TX_DATA:       tx_d = frame_d.data[bit_idx_d];
            TX_PARITY:     tx_d = parity_bit(frame_d.data, frame_d.dw, frame_d.pm);
`ifdef UART_TX_CONFIG_REQ_EN
            TX_CONFIG_REQ: tx_d = cfg_hi_d;
`endif
            default:       tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= TX_IDLE;
            cnt_q     <= 4'd0;
            bit_idx_q <= 3'd0;
            frame_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

`ifdef UART_TX_CONFIG_REQ_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_cnt_q <= '0;
            cfg_hi_q  <= 1'b0;
        end else begin
            cfg_cnt_q <= cfg_cnt_d;
            cfg_hi_q  <= cfg_hi_d;
        end
    end
`endif

    assign tx_o            = tx_q;
    assign tx_fifo_empty_o = fifo_empty;
    assign tx_busy_o       = (state_q != TX_IDLE);
    assign tx_done_o       = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;
    import uart_transmitter_pkg::*;

    logic       clk, rst, ov;
    logic [7:0] data_tx;
    logic       wr, tx_en;
    logic [1:0] dw, sb, pm;
    logic       tx_o, full, empty, busy, done;
`ifdef UART_TX_CONFIG_REQ_EN
    logic       cfg_req;
`endif

    uart_transmitter #(.FIFO_DEPTH(64), .OVERSAMPLE(16)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .ov_baud_rt_i       (ov),
        .data_tx_i          (data_tx),
        .tx_fifo_write_i    (wr),
        .data_width_i       (dw),
        .stop_bits_number_i (sb),
        .parity_mode_i      (pm),
        .tx_enable_i        (tx_en),
`ifdef UART_TX_CONFIG_REQ_EN
        .send_config_req_i  (cfg_req),
`endif
        .tx_o               (tx_o),
        .tx_fifo_full_o     (full),
        .tx_fifo_empty_o    (empty),
        .tx_busy_o          (busy),
        .tx_done_o          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample strobe every other clock
    initial begin
        ov = 1'b0;
        forever begin
            @(posedge clk);
            #1 ov = ~ov;
        end
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        string bits;
        bit    contig;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        string bits;
        bit    stable;
        bit    done_ok;
        int    gap;
    } rx_t;
    rx_t rx_q[$];

    // ---------------- line monitor ----------------
    // Samples tx_o on each strobe; 16 samples per bit, first sample names the bit.
    int   mon_len = 10;
    bit   mon_en  = 1'b1;
    bit   hunting = 1'b1;
    bit   done_pend = 1'b0;
    rx_t  cur;
    int   samp_i, gap_cnt;
    logic first_v;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst || !mon_en) begin
            hunting   = 1'b1;
            done_pend = 1'b0;
            gap_cnt   = 0;
        end else begin
            if (done_pend) begin
                done_pend   = 1'b0;
                cur.done_ok = done;
                rx_q.push_back(cur);
            end
            if (ov) begin
                if (hunting && tx_o == 1'b0) begin
                    hunting    = 1'b0;
                    cur.bits   = "";
                    cur.stable = 1'b1;
                    cur.done_ok = 1'b0;
                    cur.gap    = gap_cnt;
                    samp_i     = 0;
                    gap_cnt    = 0;
                end else if (hunting) begin
                    gap_cnt++;
                end
                if (!hunting) begin
                    if (samp_i == 0) begin
                        first_v = tx_o;
                        if (tx_o) cur.bits = {cur.bits, "1"};
                        else      cur.bits = {cur.bits, "0"};
                    end else if (tx_o !== first_v) begin
                        cur.stable = 1'b0;
                    end
                    samp_i = (samp_i + 1) % 16;
                    if (samp_i == 0 && cur.bits.len() == mon_len) begin
                        hunting   = 1'b1;
                        done_pend = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic string frame_8n1(input logic [7:0] d);
        string s;
        s = "0";
        for (int i = 0; i < 8; i++) begin
            if (d[i]) s = {s, "1"};
            else      s = {s, "0"};
        end
        s = {s, "1"};
        return s;
    endfunction

    task automatic write_byte(input logic [7:0] d);
        @(posedge clk);
        #1;
        data_tx = d;
        wr      = 1'b1;
        @(posedge clk);
        #1;
        wr      = 1'b0;
    endtask

    // Pops n expected frames and compares them with what the monitor decoded
    task automatic check_frames(input int n);
        exp_t e;
        rx_t  r;
        int   t;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (rx_q.size() == 0 && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_timeout frame=%0d no frame seen, expected one", k);
                return;
            end
            r = rx_q.pop_front();
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_frame actual=%s expected=none", r.bits);
                continue;
            end
            e = sb_q.pop_front();
            checks++;
            if (r.bits != e.bits) begin
                errors++;
                $display("FAIL frame_bits frame=%0d actual=%s expected=%s", k, r.bits, e.bits);
            end
            check("bit_16_strobes", 32'(r.stable), 32'd1);
            check("done_pulse", 32'(r.done_ok), 32'd1);
            if (e.contig) check("no_idle_gap", 32'(r.gap), 32'd0);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || !empty) && t < 2000) begin
            @(negedge clk);
            t++;
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic [1:0] dw, sb, pm;
        string      exp;
    } vec_t;
    vec_t vt[6];

    initial begin
        int   d0;
        bit   stayed_high;
        exp_t e;

        vt[0] = '{8'hA5, DW_8BIT, SB_1BIT, DISABLED1, "0101001011"};
        vt[1] = '{8'h1F, DW_5BIT, SB_2BIT, EVEN,      "011111111"};
        vt[2] = '{8'h00, DW_5BIT, SB_2BIT, ODD,       "000000111"};
        vt[3] = '{8'h5A, DW_7BIT, SB_1BIT, EVEN,      "0010110101"};
        vt[4] = '{8'hC3, DW_6BIT, 2'd3,    ODD,       "011000011"};
        vt[5] = '{8'h3C, DW_8BIT, 2'd2,    DISABLED2, "0001111001"};

        rst = 1'b1; wr = 1'b0; data_tx = 8'h00; tx_en = 1'b1;
        dw = DW_8BIT; sb = SB_1BIT; pm = DISABLED1;
`ifdef UART_TX_CONFIG_REQ_EN
        cfg_req = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // ---- table: one frame per format ----
        for (int i = 0; i < 6; i++) begin
            dw = vt[i].dw; sb = vt[i].sb; pm = vt[i].pm;
            mon_len = vt[i].exp.len();
            e.bits = vt[i].exp; e.contig = 1'b0;
            sb_q.push_back(e);
            write_byte(vt[i].data);
            check_frames(1);
            wait_idle();
            check("busy_after_done", 32'(busy), 32'd0);
            check("empty_after_frame", 32'(empty), 32'd1);
        end

        // ---- back-to-back 8N1 frames ----
        dw = DW_8BIT; sb = SB_1BIT; pm = DISABLED1; mon_len = 10;
        tx_en = 1'b0;
        d0 = done_cnt;
        write_byte(8'hFF); write_byte(8'h01); write_byte(8'h00); write_byte(8'hCF);
        sb_q.push_back('{"0111111111", 1'b0});
        sb_q.push_back('{"0100000001", 1'b1});
        sb_q.push_back('{"0000000001", 1'b1});
        sb_q.push_back('{"0111100111", 1'b1});
        tx_en = 1'b1;
        check_frames(4);
        wait_idle();
        check("b2b_done_count", 32'(done_cnt - d0), 32'd4);

        // ---- fill FIFO with transmitter held off ----
        tx_en = 1'b0;
        for (int i = 0; i < 65; i++) begin
            write_byte(8'(i * 37 + 5));
            if (i < 64) begin
                e.bits = frame_8n1(8'(i * 37 + 5));
                e.contig = (i != 0);
                sb_q.push_back(e);
            end
            if (i == 62) check("full_at_63", 32'(full), 32'd0);
            if (i == 63) check("full_at_64", 32'(full), 32'd1);
            if (i == 64) check("full_after_drop", 32'(full), 32'd1);
        end
        check("busy_while_disabled", 32'(busy), 32'd0);
        tx_en = 1'b1;
        check_frames(64);
        wait_idle();
        repeat (400) @(negedge clk);
        check("no_65th_frame", 32'(rx_q.size()), 32'd0);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        // ---- reset in the middle of a DATA bit ----
        write_byte(8'h00);
        repeat (200) @(posedge clk);
        #1;
        check("busy_mid_frame", 32'(busy), 32'd1);
        check("tx_low_mid_data", 32'(tx_o), 32'd0);
        rst = 1'b1;
        #1;
        check("tx_high_on_reset", 32'(tx_o), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("empty_after_reset", 32'(empty), 32'd1);
        check("busy_after_reset", 32'(busy), 32'd0);
        stayed_high = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || busy !== 1'b0) stayed_high = 1'b0;
        end
        check("no_resume_after_reset", 32'(stayed_high), 32'd1);
        check("no_partial_frame", 32'(rx_q.size()), 32'd0);

`ifdef UART_TX_CONFIG_REQ_EN
        // ---- configuration request start (full low phase is too long here) ----
        mon_en = 1'b0;
        @(posedge clk);
        #1 cfg_req = 1'b1;
        @(posedge clk);
        #1 cfg_req = 1'b0;
        check("cfg_tx_low", 32'(tx_o), 32'd0);
        check("cfg_busy", 32'(busy), 32'd1);
        repeat (1000) @(posedge clk);
        #1;
        check("cfg_still_low", 32'(tx_o), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
UART serial transmitter, counterpart of the receiver in the UART controller. Buffers host-written bytes in a TX FIFO and serializes each byte on tx_o as start, data (LSB first), optional parity and stop bits. Timing comes from the shared baud_rate_generator 16x oversample strobe. Frame format uses the same data-width, stop-bit and parity configuration fields as the receiver.

Parameters:
FIFO_DEPTH, 64, TX FIFO entries (power of two, at least 2)
OVERSAMPLE, 16, ov_baud_rt_i strobes per serial bit

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous, active-high
ov_baud_rt_i  input  1  1-cycle oversample strobe from baud_rate_generator
data_tx_i  input  8  byte to enqueue
tx_fifo_write_i  input  1  enqueue data_tx_i this cycle
data_width_i  input  2  DW_5BIT..DW_8BIT
stop_bits_number_i  input  2  SB_1BIT / SB_2BIT; other codes mean 1 stop bit
parity_mode_i  input  2  EVEN / ODD / disabled codes
tx_enable_i  input  1  allows a new frame to start
tx_o  output  1  serial line, idle high
tx_fifo_full_o  output  1  FIFO full
tx_fifo_empty_o  output  1  FIFO empty
tx_busy_o  output  1  frame in progress
tx_done_o  output  1  1-cycle pulse at end of last stop bit

Behaviour:
- Reset (async assert, sync release): tx_o=1, tx_fifo_empty_o=1, tx_fifo_full_o=0, tx_busy_o=0, tx_done_o=0. FIFO pointers cleared. FSM goes to IDLE. A reset mid-frame aborts the frame and tx_o returns high immediately.
- FIFO: synchronous, first-word-fall-through. A write while full is dropped and has no side effects. A simultaneous write and pop while full is accepted. Flags are registered and reflect the state after the current cycle.
- Bit timer: a 4-bit oversample counter advances only on ov_baud_rt_i. A bit ends on the strobe where the counter is OVERSAMPLE-1, so each bit lasts exactly OVERSAMPLE strobes.
- FSM IDLE: when the FIFO is not empty and tx_enable_i=1, pop the head and latch the byte, data_width_i, parity_mode_i and stop_bits_number_i. Move to START and clear the counter. Config changes mid-frame have no effect.
- FSM START: tx_o=0 for 1 bit, then go to DATA.
- FSM DATA: send bit[i] for i = 0 .. N-1, where N = 5/6/7/8. Bits above N-1 are ignored. Then go to PARITY if parity is enabled, otherwise to STOP.
- FSM PARITY: parity is the XOR of the N transmitted bits, XOR 0 for EVEN and XOR 1 for ODD.
- FSM STOP: tx_o=1 for 1 or 2 bits. On the final bit end, pulse tx_done_o. Then start the next frame immediately if a frame-start condition holds; otherwise go to IDLE. No extra idle bit between back-to-back frames.
- tx_busy_o=1 in every state except IDLE.
- tx_o is driven from a register, so it is glitch-free.
- Latency: START begins 1 clock after the pop decision. The first START strobe window counts from the next ov_baud_rt_i.

Optional Feature:
UART_TX_CONFIG_REQ_EN
- Defined: adds input send_config_req_i. In IDLE it takes priority over the FIFO and enters state CONFIG_REQ. That state drives tx_o=0 for COUNT_10MS*10 clock cycles, signalling a configuration request to the remote receiver. It then drives tx_o=1 for one bit time, pulses tx_done_o, and returns to IDLE. tx_busy_o=1 throughout.
- Undefined: the port and state are absent.

Decomposition:
- UART_pkg holds:
  - DW_5BIT=0, DW_6BIT=1, DW_7BIT=2, DW_8BIT=3
  - SB_1BIT=0, SB_2BIT=1
  - EVEN=0, ODD=1, DISABLED1=2, DISABLED2=3
  - SYSTEM_CLOCK_FREQ and COUNT_10MS=SYSTEM_CLOCK_FREQ/100
  - tx FSM state enum
- Sub-module: sync_fifo (width 8, depth FIFO_DEPTH) with write, read, full, empty, head data.

Test Plan:
- 8N1, write 0xA5 -> tx_o = 0,1,0,1,0,0,1,0,1,1, each held 16 strobes; one tx_done_o pulse; tx_busy_o falls after it.
- DW_5BIT, EVEN, SB_2BIT, write 0x1F -> 0,1,1,1,1,1, parity 1, stop 1,1. Then ODD with 0x00 -> parity 1.
- Write 0xFF, 0x01, 0x00, 0xCF back-to-back -> four contiguous frames with no idle gap, four tx_done_o pulses. Decode with the receiver loopback -> data_rx_o matches and frame_error_o=0.
- 65 writes with tx_enable_i=0 -> tx_fifo_full_o=1 after 64. The 65th is dropped, and the 64 transmitted bytes are the first 64.
- Assert rst_i during DATA -> tx_o=1 within the same cycle. After release, empty=1, busy=0 and no partial frame resumes.
- With UART_TX_CONFIG_REQ_EN, pulse send_config_req_i -> tx_o low for 10*COUNT_10MS cycles, then a high bit, then a tx_done_o pulse.
